// File: rtl/spi_register_bridge_if.sv
// Register-bus side of the SPI bridge: select/strobe/data out, combinational read value back.
interface spi_register_bridge_if #(
    parameter int SEL_W  = 4,
    parameter int DATA_W = 32
);
    logic [SEL_W-1:0]  register_select;
    logic              write_enable;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (output register_select, write_enable, write_data, input read_data);
    modport slave  (input register_select, write_enable, write_data, output read_data);
endinterface

// File: rtl/spi_register_bridge.sv
// SPI mode-0 slave turning 8-bit command + DATA_W-bit data frames into register bus accesses.
// Every SPI pin is oversampled in the CLK domain; nothing runs on SCK.
module spi_register_bridge #(
    parameter int SEL_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic CLK,
    input  logic nRST,
    input  logic SCK,
    input  logic CS_n,
    input  logic MOSI,
    output logic MISO,
    output logic frame_error,
    spi_register_bridge_if.master bus
);
    localparam int CNT_W = $clog2(DATA_W > 8 ? DATA_W : 8);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t state_q, state_d;
    // [0] first sync flop, [1] synchronized value, [2] one-cycle-delayed copy for edge detect
    logic [2:0] sck_sync_q, cs_sync_q;
    logic [1:0] mosi_sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0] cmd_sr_q, cmd_sr_d;
    logic [DATA_W-2:0] in_sr_q, in_sr_d;
    logic [DATA_W-1:0] out_sr_q, out_sr_d, write_data_q, write_data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic rw_q, rw_d, load_q, load_d, arm_q, arm_d;
    logic we_q, we_d, err_q, err_d, miso_q, miso_d;

    logic sck_rise, sck_fall, cs_fall, cs_high, mosi_s;
    logic [7:0] cmd_next;
    logic [DATA_W-1:0] word_next;

    assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_high   = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign cmd_next  = {cmd_sr_q, mosi_s};
    assign word_next = {in_sr_q, mosi_s};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_sr_d     = cmd_sr_q;
        in_sr_d      = in_sr_q;
        out_sr_d     = out_sr_q;
        write_data_d = write_data_q;
        sel_d        = sel_q;
        rw_d         = rw_q;
        load_d       = load_q;
        arm_d        = arm_q;
        we_d         = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
            end
            CMD: begin
                if (cs_high) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (sck_rise) begin
                    cmd_sr_d = cmd_next[6:0];
                    if (cnt_q == CNT_W'(7)) begin
                        sel_d    = cmd_next[SEL_W-1:0];
                        rw_d     = cmd_next[7];
                        load_d   = ~cmd_next[7];
                        arm_d    = 1'b0;
                        out_sr_d = '0;
                        cnt_d    = '0;
                        state_d  = DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (cs_high) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    load_d  = 1'b0;
                end else begin
                    if (load_q) begin
                        out_sr_d = bus.read_data;
                        load_d   = 1'b0;
                    end
                    if (sck_rise) begin
                        arm_d = 1'b1;
                        if (rw_q) in_sr_d = word_next[DATA_W-2:0];
                        if (cnt_q == CNT_W'(DATA_W-1)) begin
                            state_d = DONE;
                            if (rw_q) begin
                                write_data_d = word_next;
                                we_d         = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (sck_fall && arm_q) begin
                        // Only falls that trail a data-phase rise advance the read word
                        arm_d = 1'b0;
                        if (!rw_q) out_sr_d = out_sr_q << 1;
                    end
                end
            end
            DONE: begin
                if (cs_high) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        miso_d = (state_d == DATA && !rw_d) ? out_sr_d[DATA_W-1] : 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            sck_sync_q   <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            cnt_q        <= '0;
            cmd_sr_q     <= '0;
            in_sr_q      <= '0;
            out_sr_q     <= '0;
            write_data_q <= '0;
            sel_q        <= '0;
            rw_q         <= 1'b0;
            load_q       <= 1'b0;
            arm_q        <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            miso_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sck_sync_q   <= {sck_sync_q[1:0], SCK};
            cs_sync_q    <= {cs_sync_q[1:0], CS_n};
            mosi_sync_q  <= {mosi_sync_q[0], MOSI};
            cnt_q        <= cnt_d;
            cmd_sr_q     <= cmd_sr_d;
            in_sr_q      <= in_sr_d;
            out_sr_q     <= out_sr_d;
            write_data_q <= write_data_d;
            sel_q        <= sel_d;
            rw_q         <= rw_d;
            load_q       <= load_d;
            arm_q        <= arm_d;
            we_q         <= we_d;
            err_q        <= err_d;
            miso_q       <= miso_d;
        end
    end

    assign MISO                = miso_q;
    assign frame_error         = err_q;
    assign bus.register_select = sel_q;
    assign bus.write_enable    = we_q;
    assign bus.write_data      = write_data_q;
endmodule

// File: tb/tb_spi_register_bridge.sv
// Bench for spi_register_bridge: directed and random SPI frames against a frame-level model.
module tb_spi_register_bridge;
    localparam int SEL_W  = 4;
    localparam int DATA_W = 32;

    logic CLK = 1'b0, nRST = 1'b0, SCK = 1'b0, CS_n = 1'b1, MOSI = 1'b0;
    logic MISO, frame_error;

    spi_register_bridge_if #(.SEL_W(SEL_W), .DATA_W(DATA_W)) bus ();

    spi_register_bridge #(.SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .nRST(nRST), .SCK(SCK), .CS_n(CS_n), .MOSI(MOSI),
        .MISO(MISO), .frame_error(frame_error), .bus(bus)
    );

    // Register block stand-in: fixed contents, combinational read
    logic [DATA_W-1:0] regfile [16];
    assign bus.read_data = regfile[bus.register_select];

    always #5 CLK = ~CLK;

    int checks = 0, passes = 0;
    int we_cnt = 0, err_cnt = 0;
    logic [SEL_W-1:0] we_sel_seen = '0;

    always @(negedge CLK) begin
        if (bus.write_enable) begin
            we_cnt++;
            we_sel_seen = bus.register_select;
        end
        if (frame_error) err_cnt++;
    end

    // Expected persistent outputs
    logic [SEL_W-1:0]  exp_sel = '0;
    logic [DATA_W-1:0] exp_wd  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".sel"},  64'(bus.register_select), 64'(0));
        chk({tag, ".we"},   64'(bus.write_enable), 64'(0));
        chk({tag, ".wd"},   64'(bus.write_data), 64'(0));
        chk({tag, ".miso"}, 64'(MISO), 64'(0));
        chk({tag, ".ferr"}, 64'(frame_error), 64'(0));
    endtask

    // Drives one frame. half = SCK half period in time units (multiple of the CLK period).
    // stop_bits < 40 raises CS_n after that many bits; rst_bit >= 0 pulses nRST before that bit.
    task automatic frame(input logic [7:0] cmd, input logic [DATA_W-1:0] data, input int half,
                         input int stop_bits, input int extra, input int rst_bit,
                         output logic [DATA_W-1:0] rd, output logic miso_cmd);
        logic [39:0] frm;
        int ph;
        frm = {cmd, data};
        rd = '0;
        miso_cmd = 1'b0;
        ph = $urandom_range(1, 4) + ($urandom_range(0, 1) != 0 ? 5 : 0);
        @(posedge CLK);
        #(ph);
        CS_n = 1'b0;
        #(half);
        for (int i = 0; i < 40; i++) begin
            if (i == stop_bits) break;
            if (i == rst_bit) begin
                nRST = 1'b0;
                #3;
                chk_reset_outputs("midframe_reset");
                nRST = 1'b1;
                break;
            end
            MOSI = frm[39-i];
            #(half);
            SCK = 1'b1;
            if (i < 8) miso_cmd = miso_cmd | MISO;
            else rd = {rd[DATA_W-2:0], MISO};
            #(half);
            SCK = 1'b0;
        end
        for (int k = 0; k < extra; k++) begin
            #(half); SCK = 1'b1;
            #(half); SCK = 1'b0;
        end
        #(half);
        CS_n = 1'b1;
        #(4 * half);
    endtask

    // Frame-level model: outcome follows from how far the frame got and the command byte.
    task automatic run(input string tag, input logic [7:0] cmd, input logic [DATA_W-1:0] data,
                       input int half, input int stop_bits, input int extra, input int rst_bit);
        int we0, er0, exp_we, exp_err;
        logic [DATA_W-1:0] rd, exp_rd;
        logic miso_cmd;
        bit complete;
        we0 = we_cnt;
        er0 = err_cnt;
        complete = (stop_bits >= 40) && (rst_bit < 0);
        exp_we = 0;
        exp_err = 0;
        exp_rd = '0;
        if (rst_bit >= 0) begin
            exp_sel = '0;
            exp_wd  = '0;
        end else if (!complete) begin
            exp_err = 1;
            if (stop_bits >= 8) exp_sel = cmd[SEL_W-1:0];
        end else begin
            exp_sel = cmd[SEL_W-1:0];
            if (cmd[7]) begin
                exp_we = 1;
                exp_wd = data;
            end else begin
                exp_rd = regfile[cmd[SEL_W-1:0]];
            end
        end
        frame(cmd, data, half, stop_bits, extra, rst_bit, rd, miso_cmd);
        chk({tag, ".we_pulses"}, 64'(we_cnt - we0), 64'(exp_we));
        chk({tag, ".ferr_pulses"}, 64'(err_cnt - er0), 64'(exp_err));
        chk({tag, ".sel"}, 64'(bus.register_select), 64'(exp_sel));
        chk({tag, ".wdata"}, 64'(bus.write_data), 64'(exp_wd));
        if (exp_we == 1) chk({tag, ".we_sel"}, 64'(we_sel_seen), 64'(exp_sel));
        if (complete) begin
            chk({tag, ".miso_cmd"}, 64'(miso_cmd), 64'(0));
            chk({tag, ".miso_data"}, 64'(rd), 64'(exp_rd));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regfile[i] = $urandom;
        regfile[3] = 32'hBAD1BAD1;
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        chk_reset_outputs("reset");
        nRST = 1'b1;
        repeat (5) @(posedge CLK);

        run("t1_write", 8'h8A, 32'hDEADBEEF, 40, 40, 0, -1);
        run("t2_read",  8'h03, 32'h0,        40, 40, 0, -1);
        run("t3_abort", 8'h85, 32'h12345678, 40, 28, 0, -1);
        run("t3_after", 8'h86, 32'h00000001, 40, 40, 0, -1);
        run("t4_extra", 8'h87, 32'hA5A55A5A, 40, 40, 5, -1);
        run("t4_b2b",   8'h8F, 32'h0F0F1234, 40, 40, 0, -1);
        run("t5_rst",   8'h8C, 32'hCAFEF00D, 40, 40, 0, 18);
        run("t5_read",  8'h00, 32'h0,        40, 40, 0, -1);
        run("t6_w16",   8'h8A, 32'hDEADBEEF, 80, 40, 0, -1);
        run("t6_r16",   8'h03, 32'h0,        80, 40, 0, -1);
        run("cmd_abort", 8'h8B, 32'h0,       40, 5, 0, -1);
        for (int n = 0; n < 8; n++) begin
            logic [7:0] c;
            logic [DATA_W-1:0] d;
            c = 8'($urandom);
            d = $urandom;
            run("rand", c, d, ($urandom_range(0, 1) != 0) ? 80 : 40, 40, 0, -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
